// File: rtl/pm2_dot_acc_pkg.sv
// pm2_dot_acc_pkg: shared state encoding and product width for the dot-product accumulator
package pm2_dot_acc_pkg;
    typedef enum logic {ACC, HOLD} state_t;
    localparam int PROD_W = 4;
endpackage

// File: rtl/pm2.sv
// pm2: 2x2-bit unsigned multiplier producing a 4-bit product
module pm2
    import pm2_dot_acc_pkg::*;
(
    input  logic [1:0]        a,
    input  logic [1:0]        b,
    output logic [PROD_W-1:0] p
);
    assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/pm2_dot_acc.sv
// pm2_dot_acc: accumulates N_TERMS pm2 products into a saturating result with valid/ready output
module pm2_dot_acc
    import pm2_dot_acc_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sticky;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W:0]     w_add;
    logic               w_clamp;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_accept;
    logic               w_last;

    pm2 u_pm2 (.a(a), .b(b), .p(w_prod));

    // one extra bit on the add exposes overflow; clamp to all-ones when it is set
    assign w_add      = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
    assign w_clamp    = w_add[ACC_W];
    assign w_acc_next = w_clamp ? '1 : w_add[ACC_W-1:0];
    assign in_ready   = (r_state == ACC);
    assign out_valid  = (r_state == HOLD);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == CNT_W'(N_TERMS-1));

    // next state: finish a result on the last accept, release it on the output handshake
    always_comb begin
        w_state_next = r_state;
        if (r_state == ACC && w_accept && w_last) w_state_next = HOLD;
        if (r_state == HOLD && out_ready)         w_state_next = ACC;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_state_next;
    end

    // accumulate accepted products; on the last term publish the result and clear for the next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            sum      <= '0;
            sat      <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                sum      <= w_acc_next;
                sat      <= r_sticky | w_clamp;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_acc    <= w_acc_next;
                r_sticky <= r_sticky | w_clamp;
            end
        end
    end
endmodule

// File: tb/tb_pm2_dot_acc.sv
// tb_pm2_dot_acc: directed tests for pm2_dot_acc (default, ACC_W=5 and N_TERMS=1 instances)
module tb_pm2_dot_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    logic       v0, r0, ov0, or0, st0;
    logic [1:0] a0, b0;
    logic [7:0] s0;
    logic       v1, r1, ov1, or1, st1;
    logic [1:0] a1, b1;
    logic [4:0] s1;
    logic       v2, r2, ov2, or2, st2;
    logic [1:0] a2, b2;
    logic [7:0] s2;

    always #5 clk = ~clk;

    pm2_dot_acc #(.N_TERMS(4), .ACC_W(8)) dut0 (.clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0),
        .a(a0), .b(b0), .out_valid(ov0), .out_ready(or0), .sum(s0), .sat(st0));
    pm2_dot_acc #(.N_TERMS(4), .ACC_W(5)) dut1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .sum(s1), .sat(st1));
    pm2_dot_acc #(.N_TERMS(1), .ACC_W(8)) dut2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .sum(s2), .sat(st2));

    task automatic test_reset();
        v0 = 0; a0 = 0; b0 = 0; or0 = 1;
        v1 = 0; a1 = 0; b1 = 0; or1 = 1;
        v2 = 0; a2 = 0; b2 = 0; or2 = 1;
        rst = 1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
        n_cmp++; if (s0 !== 8'd0) begin n_err++; $display("FAIL reset_sum got=%0d exp=0", s0); end
        n_cmp++; if (st0 !== 1'b0) begin n_err++; $display("FAIL reset_sat got=%b exp=0", st0); end
        rst = 0;
        @(negedge clk);
        n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", r0); end
    endtask

    task automatic test_back_to_back();
        or0 = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (ov0 !== 1'b0 || r0 !== 1'b1) begin n_err++; $display("FAIL b2b_acc_flags term=%0d got ov=%b rdy=%b exp ov=0 rdy=1", i, ov0, r0); end
            v0 = 1; a0 = 3; b0 = 3;
        end
        @(negedge clk);
        v0 = 0;
        n_cmp++; if (ov0 !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid got=%b exp=1", ov0); end
        n_cmp++; if (s0 !== 8'd36) begin n_err++; $display("FAIL b2b_sum got=%0d exp=36", s0); end
        n_cmp++; if (st0 !== 1'b0) begin n_err++; $display("FAIL b2b_sat got=%b exp=0", st0); end
        @(negedge clk);
        n_cmp++; if (ov0 !== 1'b0 || r0 !== 1'b1) begin n_err++; $display("FAIL b2b_release got ov=%b rdy=%b exp ov=0 rdy=1", ov0, r0); end
    endtask

    task automatic test_gaps();
        logic [1:0] ta [4] = '{2'd3, 2'd3, 2'd2, 2'd2};
        logic [1:0] tb [4] = '{2'd3, 2'd1, 2'd1, 2'd2};
        or0 = 1;
        for (int i = 0; i < 4; i++) begin
            v0 = 1; a0 = ta[i]; b0 = tb[i];
            @(negedge clk);
            v0 = 0;
            if (i < 3) begin
                n_cmp++; if (r0 !== 1'b1 || ov0 !== 1'b0) begin n_err++; $display("FAIL gaps_acc_flags term=%0d got rdy=%b ov=%b exp rdy=1 ov=0", i, r0, ov0); end
                @(negedge clk);
            end
        end
        n_cmp++; if (ov0 !== 1'b1 || s0 !== 8'd18 || st0 !== 1'b0) begin n_err++; $display("FAIL gaps_result got ov=%b sum=%0d sat=%b exp ov=1 sum=18 sat=0", ov0, s0, st0); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        or0 = 0;
        for (int i = 0; i < 4; i++) begin
            v0 = 1; a0 = 1; b0 = 2;
            @(negedge clk);
        end
        a0 = 3; b0 = 3;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ov0 !== 1'b1 || r0 !== 1'b0 || s0 !== 8'd8) begin n_err++; $display("FAIL bp_hold cyc=%0d got ov=%b rdy=%b sum=%0d exp ov=1 rdy=0 sum=8", i, ov0, r0, s0); end
            if (i < 4) @(negedge clk);
        end
        or0 = 1; v0 = 0;
        @(negedge clk);
        n_cmp++; if (ov0 !== 1'b0 || r0 !== 1'b1 || s0 !== 8'd8) begin n_err++; $display("FAIL bp_release got ov=%b rdy=%b sum=%0d exp ov=0 rdy=1 sum=8", ov0, r0, s0); end
        for (int i = 0; i < 4; i++) begin
            v0 = 1; a0 = 1; b0 = 1;
            @(negedge clk);
        end
        v0 = 0;
        n_cmp++; if (ov0 !== 1'b1 || s0 !== 8'd4) begin n_err++; $display("FAIL bp_next_result got ov=%b sum=%0d exp ov=1 sum=4", ov0, s0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        or0 = 1;
        v0 = 1; a0 = 2; b0 = 2;
        @(negedge clk);
        a0 = 3; b0 = 3;
        @(negedge clk);
        v0 = 0; rst = 1;
        #1;
        n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rstmid_during got ov=%b exp=0", ov0); end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rstmid_acc term=%0d got ov=%b exp=0", i, ov0); end
            v0 = 1; a0 = 1; b0 = 1;
            @(negedge clk);
        end
        v0 = 0;
        n_cmp++; if (ov0 !== 1'b1 || s0 !== 8'd4 || st0 !== 1'b0) begin n_err++; $display("FAIL rstmid_result got ov=%b sum=%0d sat=%b exp ov=1 sum=4 sat=0", ov0, s0, st0); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        or1 = 1;
        for (int i = 0; i < 4; i++) begin
            v1 = 1; a1 = 3; b1 = 3;
            @(negedge clk);
        end
        v1 = 0;
        n_cmp++; if (ov1 !== 1'b1 || s1 !== 5'd31 || st1 !== 1'b1) begin n_err++; $display("FAIL sat_clamp got ov=%b sum=%0d sat=%b exp ov=1 sum=31 sat=1", ov1, s1, st1); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            v1 = 1; a1 = 1; b1 = 1;
            @(negedge clk);
        end
        v1 = 0;
        n_cmp++; if (ov1 !== 1'b1 || s1 !== 5'd4 || st1 !== 1'b0) begin n_err++; $display("FAIL sat_cleared got ov=%b sum=%0d sat=%b exp ov=1 sum=4 sat=0", ov1, s1, st1); end
        @(negedge clk);
    endtask

    task automatic test_n_terms_one();
        or2 = 1;
        v2 = 1; a2 = 2; b2 = 3;
        @(negedge clk);
        n_cmp++; if (ov2 !== 1'b1 || s2 !== 8'd6) begin n_err++; $display("FAIL n1_first got ov=%b sum=%0d exp ov=1 sum=6", ov2, s2); end
        a2 = 1; b2 = 3;
        @(negedge clk);
        n_cmp++; if (ov2 !== 1'b0 || r2 !== 1'b1) begin n_err++; $display("FAIL n1_gap got ov=%b rdy=%b exp ov=0 rdy=1", ov2, r2); end
        @(negedge clk);
        v2 = 0;
        n_cmp++; if (ov2 !== 1'b1 || s2 !== 8'd3) begin n_err++; $display("FAIL n1_second got ov=%b sum=%0d exp ov=1 sum=3", ov2, s2); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        test_n_terms_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
